// File: rtl/mem_pkg.sv
// Shared defaults and types for the parameterised memory controller and its
// response pipeline.
package mem_pkg;

  localparam int MEM_WIDTH = 16;
  localparam int MEM_DEPTH = 64;
  // Widest word the response struct can carry; narrower words use the low bits.
  localparam int MEM_MAX_WIDTH = 64;

  typedef enum logic {CLEAR, RUN} mem_state_e;

  typedef struct packed {
    logic                     valid;
    logic                     wr;
    logic                     err;
    logic [MEM_MAX_WIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency response delay line: RD_LAT stages of rsp_t, flushed by a
// synchronous reset so nothing in flight survives it.
module mem_rsp_pipe
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  rsp_t push,
  output rsp_t head
);

  rsp_t stage [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[RD_LAT-1];

endmodule

// File: rtl/mem_ctrl_pipe.sv
// Single-port word-addressed memory with valid/ready requests, byte-enabled
// writes, out-of-range errors, pipelined responses and a hardware clear sequence.
module mem_ctrl_pipe
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT     = 1,
  parameter int BE_WIDTH   = WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic                  clr_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_wr_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  err_o,
  output logic                  busy_o
);

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  mem_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_next;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  accept;
  logic                  in_range;
  rsp_t                  rsp_push;
  rsp_t                  rsp_head;
  logic                  unused_rsp_hi;

  assign accept   = valid_i && ready_o && !rst_i;
  assign in_range = {1'b0, addr_i} < DEPTH_EXT;
  assign busy_o   = rst_i || (state == CLEAR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready_o <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
      ready_o <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_next = clr_ptr + ADDR_WIDTH'(1);
        if (clr_ptr == LAST_ADDR) begin
          state_next   = RUN;
          clr_ptr_next = '0;
        end
      end
      RUN: begin
        // An accepted request in the same cycle still executes before the clear.
        if (clr_i) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (accept && wr_rd_i && in_range) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  // Reads sample the array at the acceptance edge; writes and errors carry zero data.
  always_comb begin
    rsp_push = '0;
    if (accept) begin
      rsp_push.valid = 1'b1;
      rsp_push.wr    = wr_rd_i;
      rsp_push.err   = !in_range;
      if (!wr_rd_i && in_range) rsp_push.data[WIDTH-1:0] = mem[addr_i];
    end
  end

  mem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (rsp_push),
    .head  (rsp_head)
  );

  assign rsp_valid_o   = rsp_head.valid;
  assign rsp_wr_o      = rsp_head.wr;
  assign err_o         = rsp_head.err;
  assign rd_data_o     = rsp_head.data[WIDTH-1:0];
  assign unused_rsp_hi = ^rsp_head.data;

endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// Scoreboard bench for mem_ctrl_pipe: instance 0 is 64 deep with RD_LAT=1,
// instance 1 is 48 deep with RD_LAT=3.
module tb_mem_ctrl_pipe;

  typedef struct {
    int          due;
    logic        wr;
    logic        err;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        valid     [2];
  logic        wr_rd     [2];
  logic [5:0]  addr      [2];
  logic [15:0] wr_data   [2];
  logic [1:0]  be        [2];
  logic        clr       [2];
  logic        ready     [2];
  logic        rsp_valid [2];
  logic        rsp_wr    [2];
  logic [15:0] rd_data   [2];
  logic        err       [2];
  logic        busy      [2];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        mon_on = 1'b0;
  logic [15:0] model [2][64];
  exp_t        q0[$];
  exp_t        q1[$];

  mem_ctrl_pipe #(.WIDTH(16), .DEPTH(64), .RD_LAT(1)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .valid_i(valid[0]), .ready_o(ready[0]),
    .wr_rd_i(wr_rd[0]), .addr_i(addr[0]), .wr_data_i(wr_data[0]), .be_i(be[0]),
    .clr_i(clr[0]), .rsp_valid_o(rsp_valid[0]), .rsp_wr_o(rsp_wr[0]),
    .rd_data_o(rd_data[0]), .err_o(err[0]), .busy_o(busy[0])
  );

  mem_ctrl_pipe #(.WIDTH(16), .DEPTH(48), .RD_LAT(3)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .valid_i(valid[1]), .ready_o(ready[1]),
    .wr_rd_i(wr_rd[1]), .addr_i(addr[1]), .wr_data_i(wr_data[1]), .be_i(be[1]),
    .clr_i(clr[1]), .rsp_valid_o(rsp_valid[1]), .rsp_wr_o(rsp_wr[1]),
    .rd_data_o(rd_data[1]), .err_o(err[1]), .busy_o(busy[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dep(int d);
    return (d == 0) ? 64 : 48;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic void q_push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic int q_size(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_pop(int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic exp_t q_front(int d);
    if (d == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void q_clear(int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard when a response appears and flags late, early or stray ones.
  task automatic monitorPort(int d);
    exp_t e;
    if (rsp_valid[d] === 1'b1) begin
      if (q_size(d) == 0) begin
        checkOutput($sformatf("d%0d rsp_unexpected", d), 32'(rsp_valid[d]), 32'd0);
      end else begin
        e = q_pop(d);
        checkOutput($sformatf("d%0d rsp_cycle", d), cyc, e.due);
        checkOutput($sformatf("d%0d rsp_wr", d), 32'(rsp_wr[d]), 32'(e.wr));
        checkOutput($sformatf("d%0d rsp_err", d), 32'(err[d]), 32'(e.err));
        checkOutput($sformatf("d%0d rsp_data", d), 32'(rd_data[d]), 32'(e.data));
      end
    end else begin
      checkOutput($sformatf("d%0d idle_outputs", d),
                  32'({rsp_valid[d], rsp_wr[d], err[d], rd_data[d]}), 32'd0);
      if (q_size(d) != 0) begin
        e = q_front(d);
        if (e.due <= cyc) begin
          e = q_pop(d);
          checkOutput($sformatf("d%0d rsp_missing", d), 32'(rsp_valid[d]), 32'd1);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      monitorPort(0);
      monitorPort(1);
    end
  end

  // Drives one request for one cycle; called and returns on a falling edge.
  task automatic applyStimulus(int d, logic w, logic [5:0] a, logic [15:0] wd,
                               logic [1:0] b, logic c);
    exp_t e;
    logic in_rng;
    checkOutput($sformatf("d%0d ready", d), 32'(ready[d]), 32'd1);
    valid[d]   = 1'b1;
    wr_rd[d]   = w;
    addr[d]    = a;
    wr_data[d] = wd;
    be[d]      = b;
    clr[d]     = c;
    in_rng = (int'(a) < dep(d));
    e.due  = cyc + lat(d);
    e.wr   = w;
    e.err  = !in_rng;
    e.data = '0;
    if (in_rng && w) begin
      for (int k = 0; k < 2; k++) if (b[k]) model[d][a][k*8 +: 8] = wd[k*8 +: 8];
    end
    if (in_rng && !w) e.data = model[d][a];
    q_push(d, e);
    if (c) for (int i = 0; i < 64; i++) model[d][i] = '0;
    @(posedge clk);
    @(negedge clk);
    valid[d] = 1'b0;
    clr[d]   = 1'b0;
  endtask

  // Counts busy cycles, optionally pulsing clr partway through, which must be ignored.
  task automatic waitClear(int d, int pulse_at);
    int cnt = 0;
    int ready_hi = 0;
    while (busy[d] === 1'b1 && cnt < 300) begin
      if (ready[d] !== 1'b0) ready_hi++;
      clr[d] = (cnt == pulse_at);
      cnt++;
      @(negedge clk);
    end
    clr[d] = 1'b0;
    checkOutput($sformatf("d%0d clear_len", d), cnt, dep(d));
    checkOutput($sformatf("d%0d ready_during_clear", d), ready_hi, 32'd0);
    checkOutput($sformatf("d%0d ready_after_clear", d), 32'(ready[d]), 32'd1);
  endtask

  task automatic drain(int d);
    for (int i = 0; i < 8 && q_size(d) != 0; i++) @(negedge clk);
    checkOutput($sformatf("d%0d drained", d), q_size(d), 32'd0);
  endtask

  task automatic scanAll(int d);
    for (int i = 0; i < dep(d); i++) applyStimulus(d, 1'b0, 6'(i), 16'h0, 2'b00, 1'b0);
    drain(d);
  endtask

  initial begin
    #200000;
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; wr_rd[d] = 1'b0; addr[d] = '0;
      wr_data[d] = '0; be[d] = '0; clr[d] = 1'b0;
      for (int i = 0; i < 64; i++) model[d][i] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    mon_on = 1'b1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d reset_ready", d), 32'(ready[d]), 32'd0);
      checkOutput($sformatf("d%0d reset_busy", d), 32'(busy[d]), 32'd1);
      checkOutput($sformatf("d%0d reset_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);

    // Post-reset clear length and an all-zero scan, one instance at a time.
    rst[0] = 1'b0;
    waitClear(0, -1);
    scanAll(0);
    rst[1] = 1'b0;
    waitClear(1, -1);
    scanAll(1);

    // Byte-enable merge, back-to-back write/read hazard and in-order responses.
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b1, 6'd5, 16'hA5C3, 2'b11, 1'b0);
      applyStimulus(d, 1'b1, 6'd5, 16'hFF00, 2'b10, 1'b0);
      applyStimulus(d, 1'b0, 6'd5, 16'h0, 2'b00, 1'b0);
      applyStimulus(d, 1'b1, 6'd9, 16'hBEEF, 2'b01, 1'b0);
      applyStimulus(d, 1'b1, 6'd9, 16'h1111, 2'b00, 1'b0);
      applyStimulus(d, 1'b0, 6'd9, 16'h0, 2'b00, 1'b0);
      drain(d);
      applyStimulus(d, 1'b1, 6'd7, 16'h1234, 2'b11, 1'b0);
      applyStimulus(d, 1'b0, 6'd7, 16'h0, 2'b11, 1'b0);
      applyStimulus(d, 1'b0, 6'd5, 16'h0, 2'b00, 1'b0);
      drain(d);
    end

    // Out-of-range accesses on the 48-deep instance, then a full rescan.
    applyStimulus(1, 1'b0, 6'd50, 16'h0, 2'b00, 1'b0);
    applyStimulus(1, 1'b1, 6'd60, 16'hDEAD, 2'b11, 1'b0);
    applyStimulus(1, 1'b0, 6'd47, 16'h0, 2'b00, 1'b0);
    applyStimulus(1, 1'b1, 6'd48, 16'hCAFE, 2'b11, 1'b0);
    drain(1);
    scanAll(1);

    // Clear request coincident with a read: the read sees the old data.
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1'b1, 6'(i), 16'h1111 * 16'(i + 1), 2'b11, 1'b0);
    applyStimulus(0, 1'b0, 6'd2, 16'h0, 2'b00, 1'b1);
    waitClear(0, 10);
    drain(0);
    scanAll(0);

    // Reset with two reads in flight while clearing: nothing emerges and the clear restarts.
    applyStimulus(1, 1'b0, 6'd5, 16'h0, 2'b00, 1'b0);
    applyStimulus(1, 1'b0, 6'd7, 16'h0, 2'b00, 1'b1);
    rst[1] = 1'b1;
    q_clear(1);
    for (int i = 0; i < 64; i++) model[1][i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    waitClear(1, 5);
    scanAll(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_pipe.md
Name: mem_ctrl_pipe

Overview:
- Parametrised, single-port, word-addressed memory block with a valid/ready request channel and a pipelined response channel.
- Generalises the existing 16x64 memory. Adds:
  - configurable width, depth and read latency;
  - byte-enabled writes;
  - out-of-range error responses;
  - a hardware clear sequence, run after reset and on request.
- Serves as the DUT behind the memory testbench BFM and monitor.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- RD_LAT, 1, cycles from request acceptance to response; legal range 1..4.
- BE_WIDTH, WIDTH/8, number of byte-enable bits.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request ready (registered).
- wr_rd_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  word address.
- wr_data_i  in  WIDTH  write data.
- be_i  in  BE_WIDTH  byte enables for writes; ignored for reads.
- clr_i  in  1  single-cycle pulse requesting a full memory clear.
- rsp_valid_o  out  1  response valid; one pulse per accepted request.
- rsp_wr_o  out  1  response belongs to a write.
- rd_data_o  out  WIDTH  read data; 0 for writes and errors.
- err_o  out  1  request address was >= DEPTH.
- busy_o  out  1  clear sequence in progress.

Behaviour:
- Reset is synchronous and active-high on rst_i; one clock, clk_i.
- While rst_i is high:
  - ready_o=0, rsp_valid_o=0, rsp_wr_o=0, rd_data_o=0, err_o=0, busy_o=1;
  - the response pipeline is flushed;
  - the FSM goes to CLEAR with clear pointer = 0.
- FSM states: CLEAR, RUN.
  - CLEAR:
    - writes 0 to one word per cycle at the pointer; pointer advances.
    - When pointer = DEPTH-1 is written, next state is RUN.
    - Takes exactly DEPTH cycles; ready_o=0 and busy_o=1 throughout.
  - RUN:
    - ready_o=1, busy_o=0.
    - On clr_i, next state is CLEAR with pointer = 0; ready_o drops on the next cycle.
- Handshake:
  - A request is accepted when valid_i && ready_o at a clock edge.
  - Inputs must be held stable while valid_i && !ready_o.
  - Throughput is one request per cycle; there is no response backpressure.
- Write accepted:
  - Each byte b with be_i[b]=1 is updated; other bytes are unchanged.
  - be_i = 0 is a legal no-op write and still returns a response.
- Read accepted: the memory word is sampled at the acceptance edge.
- Response timing:
  - The response for a request accepted at edge N appears in the cycle after edge N+RD_LAT-1.
  - RD_LAT=1 means the response is valid in the cycle following acceptance.
  - Responses are returned in request order.
- Error: addr_i >= DEPTH gives err_o=1 with the response. Writes are ignored and reads return 0.
- Back-to-back hazard: a read accepted the cycle after a write to the same address returns the new data; the write has completed at the earlier edge.
- clr_i coincident with an accepted request:
  - the request executes first;
  - the clear starts on the next cycle and overwrites the location;
  - in-flight responses still complete with their sampled data.
- clr_i during CLEAR is ignored; it does not restart the clear.
- Reset mid-clear or with responses in flight: the pipeline is dropped, no responses are emitted, and the clear restarts from 0.
- rd_data_o, rsp_wr_o and err_o are 0 whenever rsp_valid_o=0.

Decomposition:
- Package mem_pkg holds:
  - default WIDTH/DEPTH constants;
  - typedef enum logic {CLEAR, RUN} mem_state_e;
  - typedef struct packed rsp_t {valid, wr, err, data}, parameterised by width via the package constant.
- One sub-module, mem_rsp_pipe: an RD_LAT-deep shift register of rsp_t with synchronous flush.
- Storage array, FSM and handshake sit in mem_ctrl_pipe.

Test Plan:
1. Reset then idle with DEPTH=64 -> busy_o=1 and ready_o=0 for exactly 64 cycles, then ready_o=1. A read of every address returns 0x0000.
2. Write 0xA5C3 to addr 5 with be=2'b11, then write 0xFF00 with be=2'b10, then read 5 -> rd_data_o=0xFFC3. Responses arrive exactly RD_LAT cycles after each acceptance; run with RD_LAT=1 and RD_LAT=3.
3. Back-to-back: write 0x1234 to addr 7, then a read of addr 7 on the next cycle -> read response 0x1234 and rsp_wr_o=0. Three consecutive responses are in order.
4. DEPTH=48: read addr 50 -> err_o=1, rd_data_o=0. Write addr 60 -> err_o=1 and memory unchanged (rescan shows no corruption).
5. Fill addr 0..3 with nonzero data; pulse clr_i together with a read of addr 2 -> that read returns the old data. busy_o goes high for DEPTH cycles, then all words read 0.
6. Assert rst_i for 1 cycle during CLEAR and with 2 reads in flight (RD_LAT=3) -> no rsp_valid_o pulses, and the clear restarts for a full DEPTH cycles.
